// File: rtl/dma_burst_engine_if.sv
// Memory-side bus of the DMA burst engine: a source read channel and a destination write channel.
interface dma_burst_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic                    src_read;
  logic [DATA_WIDTH-1:0]   src_rdata;
  logic                    src_rvalid;
  logic                    src_rready;
  logic [ADDR_WIDTH-1:0]   dst_addr;
  logic                    dst_write;
  logic [DATA_WIDTH-1:0]   dst_wdata;
  logic [DATA_WIDTH/8-1:0] dst_wstrb;
  logic                    dst_wready;

  // A read word moves on a rising edge with src_read & src_rvalid (src_rready mirrors src_read);
  // a write word moves on a rising edge with dst_write & dst_wready. Address/data hold until then.
  modport master (output src_addr, src_read, src_rready, input src_rdata, src_rvalid,
                  output dst_addr, dst_write, dst_wdata, dst_wstrb, input dst_wready);
  modport slave  (input src_addr, src_read, src_rready, output src_rdata, src_rvalid,
                  input dst_addr, dst_write, dst_wdata, dst_wstrb, output dst_wready);
endinterface

// File: rtl/dma_burst_engine.sv
// Multi-channel round-robin DMA moving bursts through an internal buffer (read burst, then write burst).
// Optional handshake watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_burst_engine #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int CHANNEL_COUNT    = 4,
  parameter int MAX_BURST_LENGTH = 16,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  dma_burst_engine_if.master                  bus,
  input  logic [CHANNEL_COUNT-1:0]            channel_enable,
  input  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] channel_src_addr,
  input  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] channel_dst_addr,
  input  logic [CHANNEL_COUNT*32-1:0]         channel_length,
  input  logic [CHANNEL_COUNT*2-1:0]          channel_mode,
  input  logic [CHANNEL_COUNT-1:0]            channel_start,
  output logic [CHANNEL_COUNT-1:0]            channel_busy,
  output logic [CHANNEL_COUNT-1:0]            channel_done,
  output logic [CHANNEL_COUNT-1:0]            channel_error,
  output logic [2:0]                          state_dbg
);
  localparam int GW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam int KW = (MAX_BURST_LENGTH > 1) ? $clog2(MAX_BURST_LENGTH) : 1;
  localparam int BW = KW + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_LENGTH);

  if (CHANNEL_COUNT < 1 || CHANNEL_COUNT > 16 || MAX_BURST_LENGTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("dma_burst_engine: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_ARB = 3'd1, S_READ = 3'd2, S_WRITE = 3'd3, S_UPDATE = 3'd4} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]    ctx_src  [CHANNEL_COUNT];
  logic [ADDR_WIDTH-1:0]    ctx_dst  [CHANNEL_COUNT];
  logic [31:0]              ctx_rem  [CHANNEL_COUNT];
  logic [1:0]               ctx_mode [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] abort_pend, eligible, granted_oh;
  logic [DATA_WIDTH-1:0]    burst_buf [MAX_BURST_LENGTH];
  logic [GW-1:0]            grant, rr_ptr, pick;
  logic                     pick_valid;
  logic [BW-1:0]            burst_n;
  logic [KW-1:0]            beat;
  logic rd_hs, wr_hs, last_beat, timeout, others_busy, chan_abort, chan_continues;

  assign state_dbg   = state;
  assign eligible    = channel_busy & channel_enable;
  assign granted_oh  = (state == S_READ || state == S_WRITE || state == S_UPDATE)
                       ? (CHANNEL_COUNT'(1) << grant) : '0;
  assign rd_hs       = (state == S_READ) && bus.src_rvalid;
  assign wr_hs       = (state == S_WRITE) && bus.dst_wready;
  assign last_beat   = ({1'b0, beat} == burst_n - BW'(1));
  assign others_busy = |(channel_busy & ~(CHANNEL_COUNT'(1) << grant));
  // Enable falling on the granted channel is honoured only once its burst has drained.
  assign chan_abort     = abort_pend[grant] | ~channel_enable[grant];
  assign chan_continues = (ctx_rem[grant] != 32'(burst_n)) && !chan_abort;

`ifdef DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          waiting;
  assign waiting = (state == S_READ && !bus.src_rvalid) || (state == S_WRITE && !bus.dst_wready);
  assign timeout = waiting && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt <= '0;
    else if (waiting && !timeout) wd_cnt <= wd_cnt + TW'(1);
    else                         wd_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // Round robin: first eligible channel at or after rr_ptr (rr_ptr = last grant + 1).
  always_comb begin
    int idx;
    pick       = '0;
    pick_valid = 1'b0;
    for (int off = CHANNEL_COUNT - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % CHANNEL_COUNT;
      if (eligible[idx]) begin
        pick       = GW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (|channel_busy) state_nx = S_ARB;
      S_ARB:    state_nx = pick_valid ? S_READ : S_IDLE;
      S_READ:   if (timeout) state_nx = others_busy ? S_ARB : S_IDLE;
                else if (rd_hs && last_beat) state_nx = S_WRITE;
      S_WRITE:  if (timeout) state_nx = others_busy ? S_ARB : S_IDLE;
                else if (wr_hs && last_beat) state_nx = S_UPDATE;
      S_UPDATE: state_nx = (others_busy || chan_continues) ? S_ARB : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.src_addr   = '0;
    bus.src_read   = 1'b0;
    bus.src_rready = 1'b0;
    bus.dst_addr   = '0;
    bus.dst_write  = 1'b0;
    bus.dst_wdata  = '0;
    bus.dst_wstrb  = '0;
    if (state == S_READ) begin
      bus.src_addr   = ctx_src[grant];
      bus.src_read   = 1'b1;
      bus.src_rready = 1'b1;
    end
    if (state == S_WRITE) begin
      bus.dst_addr  = ctx_dst[grant];
      bus.dst_write = 1'b1;
      bus.dst_wdata = burst_buf[beat];
      bus.dst_wstrb = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= '0;
      rr_ptr  <= '0;
      burst_n <= '0;
      beat    <= '0;
    end else begin
      if (state == S_ARB && pick_valid) begin
        grant   <= pick;
        rr_ptr  <= (pick == GW'(CHANNEL_COUNT - 1)) ? '0 : pick + GW'(1);
        burst_n <= (ctx_rem[pick] > MAX_LEN) ? BW'(MAX_BURST_LENGTH) : BW'(ctx_rem[pick]);
        beat    <= '0;
      end
      if (rd_hs || wr_hs) beat <= last_beat ? '0 : beat + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_hs) burst_buf[beat] <= bus.src_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        ctx_src[i]  <= '0;
        ctx_dst[i]  <= '0;
        ctx_rem[i]  <= '0;
        ctx_mode[i] <= '0;
      end
      channel_busy  <= '0;
      channel_done  <= '0;
      channel_error <= '0;
      abort_pend    <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (channel_start[i] && channel_enable[i] && !channel_busy[i]) begin
          channel_done[i] <= 1'b0;
          if (channel_length[i*32 +: 32] == 32'd0 || channel_mode[2*i +: 2] == 2'd3) begin
            channel_error[i] <= 1'b1;
          end else begin
            ctx_src[i]       <= channel_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            ctx_dst[i]       <= channel_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            ctx_rem[i]       <= channel_length[i*32 +: 32];
            ctx_mode[i]      <= channel_mode[2*i +: 2];
            channel_busy[i]  <= 1'b1;
            channel_error[i] <= 1'b0;
            abort_pend[i]    <= 1'b0;
          end
        end else if (channel_busy[i]) begin
          if (granted_oh[i]) begin
            if (!channel_enable[i]) abort_pend[i] <= 1'b1;
            if (rd_hs && ctx_mode[i] != 2'd2) ctx_src[i] <= ctx_src[i] + STEP;
            if (wr_hs && ctx_mode[i] != 2'd1) ctx_dst[i] <= ctx_dst[i] + STEP;
            if (timeout) begin
              channel_busy[i]  <= 1'b0;
              channel_error[i] <= 1'b1;
            end else if (state == S_UPDATE) begin
              ctx_rem[i] <= ctx_rem[i] - 32'(burst_n);
              if (chan_abort) begin
                channel_busy[i]  <= 1'b0;
                channel_error[i] <= 1'b1;
              end else if (ctx_rem[i] == 32'(burst_n)) begin
                channel_busy[i] <= 1'b0;
                channel_done[i] <= 1'b1;
              end
            end
          end else if (!channel_enable[i]) begin
            channel_busy[i]  <= 1'b0;
            channel_error[i] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_burst_engine.sv
// Self-checking bench for dma_burst_engine: random-latency memory model, word-list reference model, per-scenario tasks.
module tb_dma_burst_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NCH = 4;
  localparam int MAXB = 16;
  localparam int BUDGET = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_burst_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [NCH-1:0]    channel_enable, channel_start, channel_busy, channel_done, channel_error;
  logic [NCH*AW-1:0] channel_src_addr, channel_dst_addr;
  logic [NCH*32-1:0] channel_length;
  logic [NCH*2-1:0]  channel_mode;
  logic [2:0]        state_dbg;

  dma_burst_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNEL_COUNT(NCH),
                     .MAX_BURST_LENGTH(MAXB), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .channel_enable(channel_enable), .channel_src_addr(channel_src_addr),
    .channel_dst_addr(channel_dst_addr), .channel_length(channel_length),
    .channel_mode(channel_mode), .channel_start(channel_start),
    .channel_busy(channel_busy), .channel_done(channel_done),
    .channel_error(channel_error), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Memory model: source content is a fixed function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  int   rv_pct = 100;
  int   wr_pct = 100;
  logic wr_hold = 1'b0;
  assign bus.src_rdata = bus.src_rvalid ? mem_word(bus.src_addr) : '0;
  always @(posedge clk) begin
    #1;
    bus.src_rvalid = (int'($urandom_range(99, 0)) < rv_pct);
    bus.dst_wready = !wr_hold && (int'($urandom_range(99, 0)) < wr_pct);
  end

  // Observed traffic, recorded mid-cycle for the handshakes that complete at the next edge.
  logic [AW-1:0]    rd_log[$];
  logic [AW+DW-1:0] wr_log[$];
  logic [1:0]       ph_kind[$];
  int               ph_cnt[$];
  int               strb_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dst_write && bus.dst_wstrb !== '1) strb_bad++;
      if (bus.src_read && bus.src_rvalid) begin
        rd_log.push_back(bus.src_addr);
        if (ph_kind.size() == 0 || ph_kind[ph_kind.size()-1] != 2'd1) begin
          ph_kind.push_back(2'd1); ph_cnt.push_back(1);
        end else ph_cnt[ph_cnt.size()-1]++;
      end
      if (bus.dst_write && bus.dst_wready) begin
        wr_log.push_back({bus.dst_addr, bus.dst_wdata});
        if (ph_kind.size() == 0 || ph_kind[ph_kind.size()-1] != 2'd2) begin
          ph_kind.push_back(2'd2); ph_cnt.push_back(1);
        end else ph_cnt[ph_cnt.size()-1]++;
      end
    end
  end

  // Reference model: each channel is an ordered word list; bursts are dealt round robin.
  logic [AW-1:0]    m_rd [NCH][$];
  logic [AW+DW-1:0] m_wr [NCH][$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [AW+DW-1:0] exp_q[$];

  task automatic clear_all();
    rd_log.delete(); wr_log.delete(); ph_kind.delete(); ph_cnt.delete();
    exp_rd_q.delete(); exp_q.delete();
    for (int c = 0; c < NCH; c++) begin m_rd[c].delete(); m_wr[c].delete(); end
    strb_bad = 0;
  endtask

  task automatic cfg(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                     input logic [31:0] len, input logic [1:0] mode);
    channel_src_addr[ch*AW +: AW] = s;
    channel_dst_addr[ch*AW +: AW] = d;
    channel_length[ch*32 +: 32]   = len;
    channel_mode[ch*2 +: 2]       = mode;
  endtask

  task automatic setup_chan(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int len, input logic [1:0] mode);
    logic [AW-1:0] sa, da;
    cfg(ch, s, d, 32'(len), mode);
    for (int k = 0; k < len; k++) begin
      sa = (mode == 2'd2) ? s : s + AW'(4 * k);
      da = (mode == 2'd1) ? d : d + AW'(4 * k);
      m_rd[ch].push_back(sa);
      m_wr[ch].push_back({da, mem_word(sa)});
    end
  endtask

  task automatic build_expected();
    bit any;
    do begin
      any = 0;
      for (int c = 0; c < NCH; c++) begin
        if (m_wr[c].size() > 0) begin
          any = 1;
          for (int k = 0; k < MAXB && m_wr[c].size() > 0; k++) begin
            exp_rd_q.push_back(m_rd[c].pop_front());
            exp_q.push_back(m_wr[c].pop_front());
          end
        end
      end
    end while (any);
  endtask

  function automatic int log_errors();
    int e = 0;
    if (rd_log.size() != exp_rd_q.size()) e++;
    if (wr_log.size() != exp_q.size()) e++;
    for (int i = 0; i < rd_log.size() && i < exp_rd_q.size(); i++) if (rd_log[i] !== exp_rd_q[i]) e++;
    for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) if (wr_log[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    channel_enable = '1; channel_start = '0;
    channel_src_addr = '0; channel_dst_addr = '0; channel_length = '0; channel_mode = '0;
    wr_hold = 1'b0; rv_pct = 100; wr_pct = 100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_all();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [NCH-1:0] mask);
    @(negedge clk); channel_start = mask;
    @(negedge clk); channel_start = '0;
  endtask

  task automatic wait_idle(input logic [NCH-1:0] mask, output bit ok);
    ok = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if ((channel_busy & mask) == '0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_write(output bit ok);
    ok = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (bus.dst_write) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    channel_enable = '0; channel_start = '0;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({channel_busy, channel_done, channel_error} !== '0) begin
      n_fail++; $display("FAIL reset_flags: got %0h required 0", {channel_busy, channel_done, channel_error});
    end
    n_checks++;
    if ({bus.src_read, bus.src_rready, bus.dst_write, bus.src_addr, bus.dst_addr, bus.dst_wstrb} !== '0) begin
      n_fail++; $display("FAIL reset_bus: read=%b write=%b src=%h dst=%h required all 0",
                         bus.src_read, bus.dst_write, bus.src_addr, bus.dst_addr);
    end
    do_reset();
  endtask

  task automatic test_mem2mem();
    bit ok;
    do_reset();
    setup_chan(0, 32'h1000, 32'h2000, 5, 2'd0);
    build_expected();
    @(negedge clk); channel_start = 4'b0001;
    @(posedge clk); #1; channel_start = '0;
    n_checks++;
    if (channel_busy[0] !== 1'b1 || bus.src_read !== 1'b0) begin
      n_fail++; $display("FAIL t1_start_edge: busy=%b read=%b required busy=1 read=0", channel_busy[0], bus.src_read);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.src_read !== 1'b0) begin n_fail++; $display("FAIL t1_arb_cycle: read=%b required 0", bus.src_read); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.src_read !== 1'b1 || bus.src_addr !== 32'h1000) begin
      n_fail++; $display("FAIL t1_first_read: read=%b addr=%h required 1 / 1000", bus.src_read, bus.src_addr);
    end
    wait_idle(4'b0001, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t1_timeout: busy=%b required 0 within budget", channel_busy); end
    n_checks++;
    if (log_errors() != 0) begin
      n_fail++; $display("FAIL t1_traffic: %0d differences (reads %0d/%0d writes %0d/%0d) required 0",
                         log_errors(), rd_log.size(), exp_rd_q.size(), wr_log.size(), exp_q.size());
    end
    n_checks++;
    if ({channel_done[0], channel_busy[0], channel_error[0]} !== 3'b100) begin
      n_fail++; $display("FAIL t1_flags: done/busy/err=%b required 100", {channel_done[0], channel_busy[0], channel_error[0]});
    end
  endtask

  task automatic test_multi_burst();
    int wr_at_done, rem, n, perr;
    bit ok;
    do_reset();
    rv_pct = 70; wr_pct = 70;
    setup_chan(1, $urandom() & ~32'h3, 32'h8000_0000 | ($urandom() & 32'h0FFF_FFFC), 40, 2'd0);
    build_expected();
    pulse_start(4'b0010);
    ok = 0; wr_at_done = -1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (channel_done[1]) begin ok = 1; wr_at_done = wr_log.size(); break; end
    end
    n_checks++;
    if (!ok || wr_at_done != 40) begin
      n_fail++; $display("FAIL t2_done_timing: writes at done=%0d required 40", wr_at_done);
    end
    perr = 0; rem = 40;
    for (int p = 0; rem > 0; p += 2) begin
      n = (rem < MAXB) ? rem : MAXB;
      if (p + 1 >= ph_kind.size()) perr++;
      else if (ph_kind[p] != 2'd1 || ph_cnt[p] != n || ph_kind[p+1] != 2'd2 || ph_cnt[p+1] != n) perr++;
      rem -= n;
    end
    n_checks++;
    if (perr != 0 || ph_kind.size() != 6) begin
      n_fail++; $display("FAIL t2_burst_phases: %0d bad phases of %0d required 6 phases 16/16/8", perr, ph_kind.size());
    end
    n_checks++;
    if (log_errors() != 0) begin n_fail++; $display("FAIL t2_traffic: %0d differences required 0", log_errors()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    rv_pct = 80; wr_pct = 80;
    setup_chan(0, 32'h0001_0000, 32'h0002_0000, 32, 2'd0);
    setup_chan(2, 32'h0003_0000, 32'h0004_0000, 32, 2'd0);
    build_expected();
    pulse_start(4'b0101);
    wait_idle(4'b0101, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t3_timeout: busy=%b required 0", channel_busy); end
    n_checks++;
    if (log_errors() != 0) begin n_fail++; $display("FAIL t3_interleave: %0d differences required 0", log_errors()); end
    n_checks++;
    if ((channel_done & 4'b0101) !== 4'b0101) begin
      n_fail++; $display("FAIL t3_done: done=%b required x1x1", channel_done);
    end
  endtask

  task automatic test_fixed_modes();
    bit ok;
    do_reset();
    rv_pct = 60; wr_pct = 60;
    setup_chan(3, 32'h0000_5000, 32'h4000, 3, 2'd1);
    setup_chan(2, 32'h0000_7000, 32'h0000_9000, 5, 2'd2);
    build_expected();
    pulse_start(4'b1100);
    wait_idle(4'b1100, ok);
    n_checks++;
    if (!ok || log_errors() != 0) begin
      n_fail++; $display("FAIL t4_fixed_addr: ok=%b %0d differences required 0", ok, log_errors());
    end
    n_checks++;
    if ((channel_done & 4'b1100) !== 4'b1100) begin n_fail++; $display("FAIL t4_done: done=%b required 11xx", channel_done); end
    clear_all();
    cfg(3, 32'h100, 32'h200, 32'd4, 2'd3);
    @(negedge clk); channel_start = 4'b1000;
    @(posedge clk); #1; channel_start = '0;
    n_checks++;
    if (channel_error[3] !== 1'b1 || channel_busy[3] !== 1'b0) begin
      n_fail++; $display("FAIL t4_mode3: err=%b busy=%b required 1/0", channel_error[3], channel_busy[3]);
    end
    cfg(3, 32'h100, 32'h200, 32'd0, 2'd0);
    pulse_start(4'b1000);
    n_checks++;
    if (channel_error[3] !== 1'b1 || channel_busy[3] !== 1'b0) begin
      n_fail++; $display("FAIL t4_len0: err=%b busy=%b required 1/0", channel_error[3], channel_busy[3]);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (rd_log.size() != 0 || wr_log.size() != 0) begin
      n_fail++; $display("FAIL t4_no_bus: reads=%0d writes=%0d required 0", rd_log.size(), wr_log.size());
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    wr_hold = 1'b1;
    setup_chan(1, 32'h0000_A000, 32'h0000_B000, 20, 2'd0);
    build_expected();
    while (exp_q.size() > MAXB) begin void'(exp_q.pop_back()); void'(exp_rd_q.pop_back()); end
    pulse_start(4'b0010);
    cfg(1, 32'h0000_F000, 32'h0000_E000, 32'd2, 2'd1);
    pulse_start(4'b0010);
    wait_write(ok);
    repeat (60) @(negedge clk);
    n_checks++;
    if (!ok || channel_busy[1] !== 1'b1 || channel_error[1] !== 1'b0) begin
      n_fail++; $display("FAIL t5_stall: busy=%b err=%b required 1/0", channel_busy[1], channel_error[1]);
    end
    channel_enable[1] = 1'b0;
    @(negedge clk); wr_hold = 1'b0;
    wait_idle(4'b0010, ok);
    n_checks++;
    if (!ok || {channel_error[1], channel_done[1]} !== 2'b10) begin
      n_fail++; $display("FAIL t5_drop_granted: err/done=%b required 10", {channel_error[1], channel_done[1]});
    end
    n_checks++;
    if (log_errors() != 0) begin n_fail++; $display("FAIL t5_one_burst: %0d differences required 0", log_errors()); end
    do_reset();
    wr_hold = 1'b1;
    setup_chan(0, 32'h0000_C000, 32'h0000_D000, 8, 2'd0);
    cfg(2, 32'h0001_C000, 32'h0001_D000, 32'd8, 2'd0);
    build_expected();
    pulse_start(4'b0101);
    wait_write(ok);
    channel_enable[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || channel_busy[2] !== 1'b0 || channel_error[2] !== 1'b1) begin
      n_fail++; $display("FAIL t5_drop_waiting: busy=%b err=%b required 0/1", channel_busy[2], channel_error[2]);
    end
    wr_hold = 1'b0;
    wait_idle(4'b0001, ok);
    n_checks++;
    if (!ok || channel_done[0] !== 1'b1 || log_errors() != 0) begin
      n_fail++; $display("FAIL t5_other_channel: done=%b %0d differences required 1/0", channel_done[0], log_errors());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    rv_pct = 50;
    cfg(0, 32'h0000_3000, 32'h0000_6000, 32'd30, 2'd0);
    pulse_start(4'b0001);
    ok = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (rd_log.size() >= 3) begin ok = 1; break; end
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || {bus.src_read, bus.dst_write, bus.src_addr, channel_busy, channel_done, channel_error} !== '0) begin
      n_fail++; $display("FAIL t6_async_reset: read=%b busy=%b src=%h required 0", bus.src_read, channel_busy, bus.src_addr);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_all();
    setup_chan(0, 32'h0000_3100, 32'h0000_6100, 6, 2'd0);
    build_expected();
    pulse_start(4'b0001);
    wait_idle(4'b0001, ok);
    n_checks++;
    if (!ok || channel_done[0] !== 1'b1 || log_errors() != 0) begin
      n_fail++; $display("FAIL t6_restart: done=%b %0d differences required 1/0", channel_done[0], log_errors());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [NCH-1:0] mask;
    logic [AW-1:0] s, d;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      rv_pct = int'($urandom_range(100, 30));
      wr_pct = int'($urandom_range(100, 30));
      mask = NCH'($urandom_range(15, 1));
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          s = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFE0 : ($urandom() & ~32'h3);
          d = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom() & ~32'h3);
          setup_chan(c, s, d, int'($urandom_range(40, 1)), 2'($urandom_range(2, 0)));
        end
      end
      build_expected();
      pulse_start(mask);
      wait_idle(mask, ok);
      n_checks++;
      if (!ok || log_errors() != 0 || strb_bad != 0) begin
        n_fail++; $display("FAIL rand_%0d_traffic: mask=%b %0d differences strobe errors=%0d required 0",
                           it, mask, log_errors(), strb_bad);
      end
      n_checks++;
      if ((channel_done & mask) !== mask || (channel_error & mask) !== '0) begin
        n_fail++; $display("FAIL rand_%0d_flags: done=%b err=%b required done=%b err=0", it, channel_done, channel_error, mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem2mem();
    test_multi_burst();
    test_round_robin();
    test_fixed_modes();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
